rpn_engine: RTL and testbench

RPN_ENGINE -- requirements
Module: rpn_engine

---
 rtl/rpn_engine.sv | 215 +++++++++++++++++++++
 tb/tb_rpn_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rpn_engine.sv
// rpn_engine: stack-based RPN calculator. Commands are accepted in IDLE.
// Binary ops walk FETCH -> EXEC -> WRITE. Every other command goes straight
// to WRITE, and the stack update is committed on the edge that leaves WRITE.
module rpn_engine #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [CW-1:0]    count,
  output logic             done,
  output logic             err_under,
  output logic             err_over
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0]  ONE    = CW'(1);
  localparam logic [CW-1:0]  TWO    = CW'(2);
  localparam logic [CW-1:0]  FULL   = CW'(DEPTH);
  localparam logic [WIDTH:0] SH_LIM = (WIDTH + 1)'(WIDTH);

  localparam logic [3:0] OP_PUSH  = 4'h0;
  localparam logic [3:0] OP_POP   = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_SHL   = 4'h4;
  localparam logic [3:0] OP_SHR   = 4'h5;
  localparam logic [3:0] OP_SLTU  = 4'h6;
  localparam logic [3:0] OP_AND   = 4'h7;
  localparam logic [3:0] OP_OR    = 4'h8;
  localparam logic [3:0] OP_NOR   = 4'h9;
  localparam logic [3:0] OP_XOR   = 4'hA;
  localparam logic [3:0] OP_MUL   = 4'hB;
  localparam logic [3:0] OP_SWAP  = 4'hC;
  localparam logic [3:0] OP_DUP   = 4'hD;
  localparam logic [3:0] OP_CLEAR = 4'hE;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_WRITE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   val_q, val_d;
  logic [WIDTH-1:0]   a_q, a_d;      // second entry (left operand)
  logic [WIDTH-1:0]   b_q, b_d;      // top entry (right operand)
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CW-1:0]      count_q, count_d;
  logic               done_q, done_d;
  logic               eu_q, eu_d;
  logic               eo_q, eo_d;
  logic [WIDTH-1:0]   stk_q [DEPTH];
  logic [WIDTH-1:0]   stk_d [DEPTH];

  logic [WIDTH-1:0]   top_w, next_w, alu_w;
  logic [IW-1:0]      idx_top, idx_nxt, idx_new;

  function automatic logic is_bin(input logic [3:0] o);
    return (o >= OP_ADD) && (o <= OP_MUL);
  endfunction

  assign idx_top = IW'(count_q - ONE);
  assign idx_nxt = IW'(count_q - TWO);
  assign idx_new = IW'(count_q);

  // Visible stack view: zero for entries that do not exist.
  always_comb begin
    top_w  = (count_q != '0)  ? stk_q[idx_top] : '0;
    next_w = (count_q >= TWO) ? stk_q[idx_nxt] : '0;
  end

  // ALU on the latched operands; a shift amount of WIDTH or more gives 0.
  always_comb begin
    alu_w = '0;
    case (op_q)
      OP_ADD:  alu_w = a_q + b_q;
      OP_SUB:  alu_w = a_q - b_q;
      OP_SHL:  alu_w = ({1'b0, b_q} >= SH_LIM) ? '0 : (a_q << b_q);
      OP_SHR:  alu_w = ({1'b0, b_q} >= SH_LIM) ? '0 : (a_q >> b_q);
      OP_SLTU: alu_w = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      OP_AND:  alu_w = a_q & b_q;
      OP_OR:   alu_w = a_q | b_q;
      OP_NOR:  alu_w = ~(a_q | b_q);
      OP_XOR:  alu_w = a_q ^ b_q;
      OP_MUL:  alu_w = a_q * b_q;
      default: alu_w = '0;
    endcase
  end

  // Next-state and commit logic for the command FSM and the stack.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    val_d   = val_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    count_d = count_q;
    done_d  = 1'b0;
    eu_d    = eu_q;
    eo_d    = eo_q;
    stk_d   = stk_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          op_d    = op;
          val_d   = val;
          state_d = (is_bin(op) && count_q >= TWO) ? S_FETCH : S_WRITE;
        end
      end
      S_FETCH: begin
        a_d     = next_w;
        b_d     = top_w;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_w;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (is_bin(op_q)) begin
          if (count_q < TWO) eu_d = 1'b1;
          else begin
            stk_d[idx_nxt] = res_q;
            count_d        = count_q - ONE;
          end
        end else begin
          case (op_q)
            OP_PUSH: begin
              if (count_q == FULL) eo_d = 1'b1;
              else begin
                stk_d[idx_new] = val_q;
                count_d        = count_q + ONE;
              end
            end
            OP_POP: begin
              if (count_q == '0) eu_d = 1'b1;
              else count_d = count_q - ONE;
            end
            OP_SWAP: begin
              if (count_q < TWO) eu_d = 1'b1;
              else begin
                stk_d[idx_top] = next_w;
                stk_d[idx_nxt] = top_w;
              end
            end
            OP_DUP: begin
              if (count_q == '0) eu_d = 1'b1;
              else if (count_q == FULL) eo_d = 1'b1;
              else begin
                stk_d[idx_new] = top_w;
                count_d        = count_q + ONE;
              end
            end
            OP_CLEAR: begin
              count_d = '0;
              eu_d    = 1'b0;
              eo_d    = 1'b0;
            end
            default: ;  // NOP
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state with synchronous active-low reset; aborts any command.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      val_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      eu_q    <= 1'b0;
      eo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      val_q   <= val_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      count_q <= count_d;
      done_q  <= done_d;
      eu_q    <= eu_d;
      eo_q    <= eo_d;
    end
  end

  // Stack storage; contents are hidden while count is 0, so no reset.
  always_ff @(posedge clk) begin
    stk_q <= stk_d;
  end

  assign op_ready  = (state_q == S_IDLE);
  assign top       = top_w;
  assign next      = next_w;
  assign count     = count_q;
  assign done      = done_q;
  assign err_under = eu_q;
  assign err_over  = eo_q;

endmodule

// File: tb/tb_rpn_engine.sv
// Testbench for rpn_engine: directed scenarios plus random command streams
// checked against a queue-based stack model.
module tb_rpn_engine;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [3:0]    op = 4'h0;
  logic [W-1:0]  val = '0;
  logic [W-1:0]  top, next;
  logic [CW-1:0] count;
  logic          done, err_under, err_over;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue, back = top of stack.
  longint unsigned mq[$];
  bit m_under = 0, m_over = 0;
  localparam longint unsigned MASK = (64'd1 << W) - 1;

  rpn_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .val(val), .top(top), .next(next), .count(count),
    .done(done), .err_under(err_under), .err_over(err_over)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned m_alu(input int o, input longint unsigned a,
                                            input longint unsigned b);
    case (o)
      2:  return (a + b) & MASK;
      3:  return (a - b) & MASK;
      4:  return (b >= W) ? 0 : ((a << b) & MASK);
      5:  return (b >= W) ? 0 : (a >> b);
      6:  return (a < b) ? 1 : 0;
      7:  return a & b;
      8:  return a | b;
      9:  return (~(a | b)) & MASK;
      10: return a ^ b;
      11: return (a * b) & MASK;
      default: return 0;
    endcase
  endfunction

  // Applies one command to the model; returns expected cycles to done.
  function automatic int m_apply(input int o, input longint unsigned v);
    longint unsigned a, b;
    int n = mq.size();
    if (o >= 2 && o <= 11) begin
      if (n < 2) begin m_under = 1; return 1; end
      b = mq.pop_back(); a = mq.pop_back();
      mq.push_back(m_alu(o, a, b));
      return 3;
    end
    case (o)
      0:  if (n == D) m_over = 1; else mq.push_back(v & MASK);
      1:  if (n == 0) m_under = 1; else void'(mq.pop_back());
      12: if (n < 2) m_under = 1;
          else begin b = mq.pop_back(); a = mq.pop_back(); mq.push_back(b); mq.push_back(a); end
      13: if (n == 0) m_under = 1; else if (n == D) m_over = 1; else mq.push_back(mq[n-1]);
      14: begin mq.delete(); m_under = 0; m_over = 0; end
      default: ;
    endcase
    return 1;
  endfunction

  function automatic longint unsigned m_top();
    return (mq.size() > 0) ? mq[mq.size()-1] : 0;
  endfunction
  function automatic longint unsigned m_next();
    return (mq.size() > 1) ? mq[mq.size()-2] : 0;
  endfunction

  // Drives one command, steps the model, and measures cycles until done.
  task automatic run_cmd(input int o, input int v, output int lat, output int exp_lat,
                         output int lows);
    @(negedge clk);
    op_valid = 1'b1; op = 4'(o); val = W'(v);
    exp_lat = m_apply(o, longint'(v));
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'($urandom); val = W'($urandom);
    lat = 0; lows = 0;
    do begin
      if (!op_ready) lows++;
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 10);
  endtask

  task automatic test_reset();
    rst = 1'b0; op_valid = 1'b1; op = 4'h0; val = 16'h55;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", op_ready); end
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (top !== '0 || next !== '0) begin n_fail++; $display("FAIL reset_top_next: got %h/%h want 0/0", top, next); end
    n_checks++; if ({done, err_under, err_over} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {done, err_under, err_over}); end
    @(negedge clk); rst = 1'b1; op_valid = 1'b0;
    mq.delete(); m_under = 0; m_over = 0;
  endtask

  task automatic test_add();
    int lat, el, lows;
    run_cmd(0, 7, lat, el, lows);
    run_cmd(0, 3, lat, el, lows);
    run_cmd(2, 0, lat, el, lows);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d want 3", lat); end
    n_checks++; if (lows !== 3) begin n_fail++; $display("FAIL add_ready_low: got %0d want 3", lows); end
    n_checks++; if (top !== 16'd10 || count !== 3'd1) begin n_fail++; $display("FAIL add_result: got top=%0d cnt=%0d want 10/1", top, count); end
    run_cmd(14, 0, lat, el, lows);
  endtask

  task automatic test_sub_shift();
    int lat, el, lows;
    run_cmd(0, 5, lat, el, lows); run_cmd(0, 9, lat, el, lows); run_cmd(3, 0, lat, el, lows);
    n_checks++; if (top !== 16'hFFFC) begin n_fail++; $display("FAIL sub_wrap: got %h want fffc", top); end
    run_cmd(0, 2, lat, el, lows); run_cmd(4, 0, lat, el, lows);
    n_checks++; if (top !== 16'hFFF0) begin n_fail++; $display("FAIL shl: got %h want fff0", top); end
    run_cmd(0, 16, lat, el, lows); run_cmd(5, 0, lat, el, lows);
    n_checks++; if (top !== 16'h0 || count !== 3'd1) begin n_fail++; $display("FAIL shr_big: got %h cnt=%0d want 0/1", top, count); end
    run_cmd(14, 0, lat, el, lows);
  endtask

  task automatic test_swap_dup();
    int lat, el, lows;
    run_cmd(0, 1, lat, el, lows); run_cmd(0, 2, lat, el, lows); run_cmd(12, 0, lat, el, lows);
    n_checks++; if (top !== 16'd1 || next !== 16'd2 || lat !== 1) begin n_fail++; $display("FAIL swap: got %0d/%0d lat=%0d want 1/2 lat=1", top, next, lat); end
    run_cmd(6, 0, lat, el, lows);
    n_checks++; if (top !== 16'd0) begin n_fail++; $display("FAIL sltu: got %0d want 0", top); end
    run_cmd(13, 0, lat, el, lows);
    n_checks++; if (top !== 16'd0 || next !== 16'd0 || count !== 3'd2) begin n_fail++; $display("FAIL dup: got %0d/%0d cnt=%0d want 0/0/2", top, next, count); end
    run_cmd(14, 0, lat, el, lows);
  endtask

  task automatic test_over_under();
    int lat, el, lows;
    for (int i = 1; i <= 4; i++) run_cmd(0, i, lat, el, lows);
    run_cmd(0, 5, lat, el, lows);
    n_checks++; if (err_over !== 1'b1 || count !== 3'd4 || top !== 16'd4 || lat !== 1) begin n_fail++; $display("FAIL overflow: got ov=%b cnt=%0d top=%0d lat=%0d want 1/4/4/1", err_over, count, top, lat); end
    for (int i = 0; i < 5; i++) run_cmd(1, 0, lat, el, lows);
    n_checks++; if (err_under !== 1'b1 || count !== 3'd0 || err_over !== 1'b1) begin n_fail++; $display("FAIL underflow: got un=%b ov=%b cnt=%0d want 1/1/0", err_under, err_over, count); end
    run_cmd(2, 0, lat, el, lows);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL under_bin_latency: got %0d want 1", lat); end
    run_cmd(14, 0, lat, el, lows);
    n_checks++; if (err_under !== 1'b0 || err_over !== 1'b0) begin n_fail++; $display("FAIL clear_flags: got %b%b want 00", err_under, err_over); end
  endtask

  task automatic test_reset_mid();
    int lat, el, lows;
    run_cmd(0, 1, lat, el, lows); run_cmd(0, 2, lat, el, lows);
    @(negedge clk); op_valid = 1'b1; op = 4'h2;
    @(posedge clk); #1; op_valid = 1'b0;      // accept edge E0
    @(posedge clk);                            // E0+1: now in EXEC
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;                        // E0+2 is a reset edge
    n_checks++; if (count !== '0 || done !== 1'b0 || op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid: got cnt=%0d done=%b rdy=%b want 0/0/1", count, done, op_ready); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0 || count !== '0) begin n_fail++; $display("FAIL reset_mid_nocommit: got done=%b cnt=%0d want 0/0", done, count); end
    mq.delete(); m_under = 0; m_over = 0;
  endtask

  task automatic test_hold_valid();
    int lat, el, lows;
    bit seen_done;
    run_cmd(14, 0, lat, el, lows);
    seen_done = 0;
    @(negedge clk); op_valid = 1'b1; op = 4'h0; val = 16'd6;   // edge 0 accepts
    @(negedge clk); op = 4'h1; val = 16'd9;                     // edge 1 commits
    @(negedge clk); op = 4'h0; val = 16'd6;                     // edge 2 accepts
    @(negedge clk); op = 4'h4; val = 16'd1;                     // edge 3 commits
    @(posedge clk); #1; seen_done = done;
    @(negedge clk); op_valid = 1'b0;
    void'(m_apply(0, 6)); void'(m_apply(0, 6));
    n_checks++; if (count !== 3'd2 || top !== 16'd6 || next !== 16'd6) begin n_fail++; $display("FAIL hold_valid: got cnt=%0d top=%0d next=%0d want 2/6/6", count, top, next); end
    n_checks++; if (seen_done !== 1'b1) begin n_fail++; $display("FAIL hold_valid_done: got %b want 1", seen_done); end
    run_cmd(14, 0, lat, el, lows);
  endtask

  task automatic test_random();
    int lat, el, lows, o, v;
    for (int i = 0; i < 400; i++) begin
      o = int'($urandom_range(0, 15));
      if (o == 14 && $urandom_range(0, 3) != 0) o = 0;
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom & 32'hFFFF);
      run_cmd(o, v, lat, el, lows);
      n_checks++;
      if (lat !== el || top !== W'(m_top()) || next !== W'(m_next()) || count !== CW'(mq.size())
          || err_under !== m_under || err_over !== m_over || op_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0h: got lat=%0d top=%h next=%h cnt=%0d un=%b ov=%b want lat=%0d top=%h next=%h cnt=%0d un=%b ov=%b",
                 i, o, lat, top, next, count, err_under, err_over,
                 el, W'(m_top()), W'(m_next()), mq.size(), m_under, m_over);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_shift();
    test_swap_dup();
    test_over_under();
    test_reset_mid();
    test_hold_valid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
